// File: rtl/fetch_stage.sv
// Instruction fetch stage: a single outstanding word read, a registered IF/ID latch,
// redirect with stale-response discard, and a halt on memory error or misaligned target.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic [36:0] mem_read_req,
    input  logic [65:0] mem_read_rsp,
    output logic [64:0] if_id,
    output logic        fault
);
    // mem_read_req = {addr[31:0], mask[3:0], en}; mem_read_rsp = {addr, data, valid, done};
    // if_id = {inst[31:0], pc[31:0], valid}
    localparam logic [3:0]  MEM_REQ_WORD_MASK = 4'hF;
    localparam logic [36:0] MEM_READ_REQ_RST  = 37'd0;
    localparam logic [64:0] IF_ID_RST         = 65'd0;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_OUT  = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        discard_q, discard_d;
    logic        fault_q, fault_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        id_valid_q, id_valid_d;

    logic        rsp_done_s;
    logic        rsp_valid_s;
    logic [31:0] rsp_data_s;
    logic        redir_ok_s;
    logic        redir_bad_s;
    logic        issue_s;
    logic        unused_rsp_addr_s;

    assign rsp_done_s        = mem_read_rsp[0];
    assign rsp_valid_s       = mem_read_rsp[1];
    assign rsp_data_s        = mem_read_rsp[33:2];
    assign unused_rsp_addr_s = ^mem_read_rsp[65:34];
    assign redir_ok_s        = redirect_en && (redirect_pc[1:0] == 2'b00);
    assign redir_bad_s       = redirect_en && (redirect_pc[1:0] != 2'b00);

    // A misaligned redirect in REQ suppresses the request so that nothing is left outstanding.
    assign issue_s      = rst_n && (state_q == ST_REQ) && !redir_bad_s;
    assign mem_read_req = issue_s ? {pc_q, MEM_REQ_WORD_MASK, 1'b1} : MEM_READ_REQ_RST;
    assign if_id        = {inst_q, id_pc_q, id_valid_q};
    assign fault        = fault_q;

    // Next-state logic: redirect outranks stall and memory responses in every state.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        discard_d  = discard_q;
        fault_d    = fault_q;
        inst_d     = inst_q;
        id_pc_d    = id_pc_q;
        id_valid_d = id_valid_q;
        case (state_q)
            ST_REQ: begin
                // A stale response left over from before a reset is consumed here.
                discard_d = discard_q && !rsp_done_s;
                if (redir_bad_s) begin
                    fault_d    = 1'b1;
                    id_valid_d = 1'b0;
                    state_d    = ST_HALT;
                end else if (redir_ok_s) begin
                    pc_d       = redirect_pc;
                    discard_d  = 1'b1;
                    id_valid_d = 1'b0;
                    state_d    = ST_WAIT;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redir_bad_s) begin
                    fault_d    = 1'b1;
                    id_valid_d = 1'b0;
                    discard_d  = !rsp_done_s;
                    state_d    = ST_HALT;
                end else if (redir_ok_s) begin
                    pc_d       = redirect_pc;
                    id_valid_d = 1'b0;
                    discard_d  = !rsp_done_s;
                    state_d    = rsp_done_s ? ST_REQ : ST_WAIT;
                end else if (rsp_done_s) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = ST_REQ;
                    end else if (rsp_valid_s) begin
                        inst_d     = rsp_data_s;
                        id_pc_d    = pc_q;
                        id_valid_d = 1'b1;
                        pc_d       = pc_q + 32'd4;
                        state_d    = ST_OUT;
                    end else begin
                        fault_d    = 1'b1;
                        id_valid_d = 1'b0;
                        state_d    = ST_HALT;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_OUT: begin
                if (redir_bad_s) begin
                    fault_d    = 1'b1;
                    id_valid_d = 1'b0;
                    state_d    = ST_HALT;
                end else if (redir_ok_s) begin
                    pc_d       = redirect_pc;
                    id_valid_d = 1'b0;
                    state_d    = ST_REQ;
                end else if (!stall) begin
                    id_valid_d = 1'b0;
                    state_d    = ST_REQ;
                end else begin
                    state_d = ST_OUT;
                end
            end
            ST_HALT: begin
                discard_d = discard_q && !rsp_done_s;
                if (redir_ok_s) begin
                    pc_d       = redirect_pc;
                    fault_d    = 1'b0;
                    id_valid_d = 1'b0;
                    state_d    = (discard_q && !rsp_done_s) ? ST_WAIT : ST_REQ;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                fault_d    = 1'b1;
                id_valid_d = 1'b0;
                state_d    = ST_HALT;
            end
        endcase
    end

    // State registers; reset remembers an abandoned in-flight read so its late response is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q                           <= ST_REQ;
            pc_q                              <= RESET_PC;
            discard_q                         <= (discard_q || (state_q == ST_WAIT)) && !rsp_done_s;
            fault_q                           <= 1'b0;
            {inst_q, id_pc_q, id_valid_q}     <= IF_ID_RST;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            discard_q  <= discard_d;
            fault_q    <= fault_d;
            inst_q     <= inst_d;
            id_pc_q    <= id_pc_d;
            id_valid_q <= id_valid_d;
        end
    end
endmodule
